// File: rtl/ipif_table_store_if.sv
// Host read/write, datapath lookup and acknowledge signals of the table store.
// Width parameters must match the ipif_table_store instance bound to it.
interface ipif_table_store_if #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int TBL_NUM_COLS       = 4,
   parameter int TBL_NUM_ROWS       = 4
);
   localparam int W = TBL_NUM_COLS * C_S_AXI_DATA_WIDTH;
   localparam int A = (TBL_NUM_ROWS > 1) ? $clog2(TBL_NUM_ROWS) : 1;

   // Host side: req is a level held until its one-cycle ack, then dropped.
   // Lookup side: a lookup issues in any cycle where lkp_req && lkp_ready;
   // its result appears as a one-cycle lkp_ack with lkp_data two cycles later.
   logic         tbl_rd_req;
   logic         tbl_rd_ack;
   logic [A-1:0] tbl_rd_addr;
   logic [W-1:0] tbl_rd_data;
   logic         tbl_wr_req;
   logic         tbl_wr_ack;
   logic [A-1:0] tbl_wr_addr;
   logic [W-1:0] tbl_wr_data;
   logic         lkp_req;
   logic         lkp_ready;
   logic [A-1:0] lkp_addr;
   logic         lkp_ack;
   logic [W-1:0] lkp_data;

   modport master (
      output tbl_rd_req, tbl_rd_addr, tbl_wr_req, tbl_wr_addr, tbl_wr_data,
             lkp_req, lkp_addr,
      input  tbl_rd_ack, tbl_rd_data, tbl_wr_ack, lkp_ready, lkp_ack, lkp_data
   );

   modport slave (
      input  tbl_rd_req, tbl_rd_addr, tbl_wr_req, tbl_wr_addr, tbl_wr_data,
             lkp_req, lkp_addr,
      output tbl_rd_ack, tbl_rd_data, tbl_wr_ack, lkp_ready, lkp_ack, lkp_data
   );
endinterface

// File: rtl/ipif_table_store.sv
// Single-port row table shared by a pipelined lookup path and a host FSM.
// Define IPIF_TABLE_STORE_FAIRNESS_EN to bound host starvation by lookups.
module ipif_table_store #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int TBL_NUM_COLS       = 4,
   parameter int TBL_NUM_ROWS       = 4,
   parameter int STARVE_LIMIT       = 7
) (
   input  logic              Bus2IP_Clk,
   input  logic              Bus2IP_Resetn,
   ipif_table_store_if.slave bus,
   output logic [2:0]        dbg_state
);
   localparam int W = TBL_NUM_COLS * C_S_AXI_DATA_WIDTH;
   localparam int A = (TBL_NUM_ROWS > 1) ? $clog2(TBL_NUM_ROWS) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PEND    = 3'd1,
      RD_PIPE = 3'd2,
      ACK     = 3'd3,
      DROP    = 3'd4
   } state_t;

   state_t       state;
   state_t       state_nxt;
   logic         op_wr;
   logic [A-1:0] host_addr;
   logic [W-1:0] host_data;
   logic [W-1:0] mem [TBL_NUM_ROWS];
   logic [W-1:0] port_q;
   logic [A-1:0] port_addr;
   logic         lkp_issue;
   logic         host_grant;
   logic         lkp_v1;

   assign lkp_issue  = bus.lkp_req & bus.lkp_ready;
   assign host_grant = (state == PEND) & ~lkp_issue;
   assign port_addr  = lkp_issue ? bus.lkp_addr : host_addr;
   assign dbg_state  = state;

`ifdef IPIF_TABLE_STORE_FAIRNESS_EN
   logic [3:0] starve_cnt;

   // Withholding ready for one cycle hands the port to the waiting host.
   assign bus.lkp_ready = ~((state == PEND) && (starve_cnt == 4'(STARVE_LIMIT)));

   always_ff @(posedge Bus2IP_Clk) begin
      if (!Bus2IP_Resetn)
         starve_cnt <= '0;
      else if (state_nxt != PEND)
         starve_cnt <= '0;
      else if ((state == PEND) && lkp_issue)
         starve_cnt <= starve_cnt + 4'd1;
   end
`else
   assign bus.lkp_ready = 1'b1;
`endif

   always_comb begin
      state_nxt      = state;
      bus.tbl_wr_ack = 1'b0;
      bus.tbl_rd_ack = 1'b0;
      case (state)
         IDLE:    if (bus.tbl_wr_req || bus.tbl_rd_req) state_nxt = PEND;
         PEND:    if (host_grant) state_nxt = op_wr ? ACK : RD_PIPE;
         RD_PIPE: state_nxt = ACK;
         ACK: begin
            state_nxt      = DROP;
            bus.tbl_wr_ack = op_wr;
            bus.tbl_rd_ack = ~op_wr;
         end
         // Only the request that was acknowledged releases DROP.
         DROP:    if (!(op_wr ? bus.tbl_wr_req : bus.tbl_rd_req)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Bus2IP_Clk) begin
      if (!Bus2IP_Resetn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Write wins when both requests arrive together in IDLE.
   always_ff @(posedge Bus2IP_Clk) begin
      if ((state == IDLE) && (bus.tbl_wr_req || bus.tbl_rd_req)) begin
         op_wr     <= bus.tbl_wr_req;
         host_addr <= bus.tbl_wr_req ? bus.tbl_wr_addr : bus.tbl_rd_addr;
         host_data <= bus.tbl_wr_data;
      end
   end

   // Contents survive reset, but a write colliding with reset is dropped.
   always_ff @(posedge Bus2IP_Clk) begin
      if (Bus2IP_Resetn && host_grant && op_wr)
         mem[host_addr] <= host_data;
      port_q <= mem[port_addr];
   end

   always_ff @(posedge Bus2IP_Clk) begin
      if (!Bus2IP_Resetn) begin
         lkp_v1       <= 1'b0;
         bus.lkp_ack  <= 1'b0;
         bus.lkp_data <= '0;
      end else begin
         lkp_v1      <= lkp_issue;
         bus.lkp_ack <= lkp_v1;
         if (lkp_v1)
            bus.lkp_data <= port_q;
      end
   end

   always_ff @(posedge Bus2IP_Clk) begin
      if (!Bus2IP_Resetn)
         bus.tbl_rd_data <= '0;
      else if (state == RD_PIPE)
         bus.tbl_rd_data <= port_q;
   end
endmodule

// File: tb/tb_ipif_table_store.sv
// Randomized bench for ipif_table_store against a cycle-stamped table model.
// Expectations follow the FAIRNESS build when IPIF_TABLE_STORE_FAIRNESS_EN is defined.
module tb_ipif_table_store;
   localparam int DW     = 32;
   localparam int COLS   = 4;
   localparam int ROWS   = 4;
   localparam int STARVE = 7;
   localparam int W      = DW * COLS;
   localparam int A      = $clog2(ROWS);
   localparam logic [W-1:0] PAT_A5 = {(W / 8){8'hA5}};

   logic       clk = 1'b0;
   logic       rstn;
   logic [2:0] dbg_state;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;

   logic [W-1:0] model [ROWS];
   logic [W-1:0] exp_q[$];
   int           exp_cyc_q[$];

   ipif_table_store_if #(.C_S_AXI_DATA_WIDTH(DW), .TBL_NUM_COLS(COLS), .TBL_NUM_ROWS(ROWS)) tif ();

   ipif_table_store #(
      .C_S_AXI_DATA_WIDTH(DW), .TBL_NUM_COLS(COLS),
      .TBL_NUM_ROWS(ROWS), .STARVE_LIMIT(STARVE)
   ) dut (
      .Bus2IP_Clk(clk), .Bus2IP_Resetn(rstn), .bus(tif), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] rand_row();
      logic [W-1:0] r;
      r = '0;
      repeat ((W + 31) / 32) r = (r << 32) | W'($urandom);
      return r;
   endfunction

   // Every cycle: an expected lookup result must appear exactly on its stamp.
   task automatic monitor_lkp();
      forever begin
         @(negedge clk);
         n_checks++;
         if (exp_cyc_q.size() != 0 && exp_cyc_q[0] == cyc) begin
            if (tif.lkp_ack !== 1'b1 || tif.lkp_data !== exp_q[0]) begin
               n_fail++;
               $display("FAIL lkp_result cyc %0d: got ack %b data %h expected ack 1 data %h",
                        cyc, tif.lkp_ack, tif.lkp_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
         end else if (tif.lkp_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL lkp_unexpected_ack cyc %0d: got %b expected 0", cyc, tif.lkp_ack);
         end
      end
   endtask

   task automatic host_write(input logic [A-1:0] a, input logic [W-1:0] d);
      int c0;
      bit seen;
      c0 = cyc; seen = 1'b0;
      tif.tbl_wr_req = 1'b1; tif.tbl_wr_addr = a; tif.tbl_wr_data = d;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         n_checks++;
         if (tif.tbl_rd_ack !== 1'b0) begin
            n_fail++; $display("FAIL wr_rd_ack_spurious: got %b expected 0", tif.tbl_rd_ack);
         end
         if (tif.tbl_wr_ack === 1'b1) begin
            seen = 1'b1; tif.tbl_wr_req = 1'b0;
            n_checks++;
            if (cyc != c0 + 2) begin
               n_fail++; $display("FAIL wr_ack_latency: got %0d expected 2", cyc - c0);
            end
         end
      end
      n_checks++;
      if (!seen) begin
         n_fail++; $display("FAIL wr_ack_timeout: got no ack expected ack at +2");
         tif.tbl_wr_req = 1'b0;
      end
      model[a] = d;
      @(negedge clk);
      n_checks++;
      if (tif.tbl_wr_ack !== 1'b0) begin
         n_fail++; $display("FAIL wr_ack_single: got %b expected 0", tif.tbl_wr_ack);
      end
      @(negedge clk);
   endtask

   task automatic host_read(input logic [A-1:0] a);
      int c0;
      bit seen;
      c0 = cyc; seen = 1'b0;
      tif.tbl_rd_req = 1'b1; tif.tbl_rd_addr = a;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         n_checks++;
         if (tif.tbl_wr_ack !== 1'b0) begin
            n_fail++; $display("FAIL rd_wr_ack_spurious: got %b expected 0", tif.tbl_wr_ack);
         end
         if (tif.tbl_rd_ack === 1'b1) begin
            seen = 1'b1; tif.tbl_rd_req = 1'b0;
            n_checks += 2;
            if (cyc != c0 + 3) begin
               n_fail++; $display("FAIL rd_ack_latency: got %0d expected 3", cyc - c0);
            end
            if (tif.tbl_rd_data !== model[a]) begin
               n_fail++; $display("FAIL rd_data row %0d: got %h expected %h", a, tif.tbl_rd_data, model[a]);
            end
         end
      end
      n_checks++;
      if (!seen) begin
         n_fail++; $display("FAIL rd_ack_timeout: got no ack expected ack at +3");
         tif.tbl_rd_req = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (tif.tbl_rd_ack !== 1'b0 || tif.tbl_rd_data !== model[a]) begin
         n_fail++;
         $display("FAIL rd_hold: got ack %b data %h expected ack 0 data %h", tif.tbl_rd_ack, tif.tbl_rd_data, model[a]);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      n_checks += 6;
      if (tif.tbl_rd_ack !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ack: got %b expected 0", tif.tbl_rd_ack); end
      if (tif.tbl_wr_ack !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ack: got %b expected 0", tif.tbl_wr_ack); end
      if (tif.lkp_ack !== 1'b0) begin n_fail++; $display("FAIL reset_lkp_ack: got %b expected 0", tif.lkp_ack); end
      if (tif.tbl_rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", tif.tbl_rd_data); end
      if (tif.lkp_data !== '0) begin n_fail++; $display("FAIL reset_lkp_data: got %h expected 0", tif.lkp_data); end
      if (tif.lkp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_lkp_ready: got %b expected 1", tif.lkp_ready); end
   endtask

   task automatic test_host_access();
      for (int r = 0; r < ROWS; r++) host_write(A'(r), rand_row());
      host_write(A'(2), PAT_A5);
      host_read(A'(2));
      repeat (4) host_read(A'($urandom_range(0, ROWS - 1)));
   endtask

   task automatic test_lookup_stream();
      for (int i = 0; i < 20; i++) begin
         tif.lkp_req = 1'b1; tif.lkp_addr = A'(i % ROWS);
         exp_q.push_back(model[i % ROWS]); exp_cyc_q.push_back(cyc + 2);
         @(negedge clk);
      end
      tif.lkp_req = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL lkp_stream_drain: got %0d pending expected 0", exp_q.size());
      end
   endtask

   task automatic test_starvation();
      int s, l, g_pred, ready_low, c, a;
      logic [A-1:0] wa;
      logic [W-1:0] wd;
      bit exp_ready;
      wa = A'($urandom_range(0, ROWS - 1)); wd = rand_row();
      s = cyc + 2; l = cyc + 19;
`ifdef IPIF_TABLE_STORE_FAIRNESS_EN
      g_pred = s + 1 + STARVE; ready_low = g_pred;
`else
      g_pred = l + 1; ready_low = -1;
`endif
      for (int k = 0; k < 26; k++) begin
         c = cyc;
         exp_ready = (c != ready_low);
         n_checks += 2;
         if (tif.lkp_ready !== exp_ready) begin
            n_fail++; $display("FAIL starve_lkp_ready cyc %0d: got %b expected %b", c, tif.lkp_ready, exp_ready);
         end
         if (tif.tbl_wr_ack !== (c == g_pred + 1)) begin
            n_fail++; $display("FAIL starve_wr_ack cyc %0d: got %b expected %b", c, tif.tbl_wr_ack, (c == g_pred + 1));
         end
         if (tif.tbl_wr_ack === 1'b1) tif.tbl_wr_req = 1'b0;
         if (c == s) begin
            tif.tbl_wr_req = 1'b1; tif.tbl_wr_addr = wa; tif.tbl_wr_data = wd;
         end
         if (c <= l) begin
            a = $urandom_range(0, ROWS - 1);
            tif.lkp_req = 1'b1; tif.lkp_addr = A'(a);
            if (exp_ready) begin
               exp_q.push_back(model[a]); exp_cyc_q.push_back(c + 2);
            end
         end else begin
            tif.lkp_req = 1'b0;
         end
         if (c == g_pred) model[wa] = wd;
         @(negedge clk);
      end
      tif.tbl_wr_req = 1'b0;
      tif.lkp_req = 1'b1; tif.lkp_addr = wa;
      exp_q.push_back(model[wa]); exp_cyc_q.push_back(cyc + 2);
      @(negedge clk);
      tif.lkp_req = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_wr_rd_collision();
      int c0, d;
      bit seen;
      logic [W-1:0] x;
      x = rand_row(); c0 = cyc; seen = 1'b0;
      tif.tbl_wr_req = 1'b1; tif.tbl_rd_req = 1'b1;
      tif.tbl_wr_addr = A'(1); tif.tbl_rd_addr = A'(1); tif.tbl_wr_data = x;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         n_checks += 2;
         if (tif.tbl_rd_ack !== 1'b0) begin
            n_fail++; $display("FAIL both_rd_early cyc %0d: got %b expected 0", cyc, tif.tbl_rd_ack);
         end
         if (tif.tbl_wr_ack !== (cyc == c0 + 2)) begin
            n_fail++; $display("FAIL both_wr_ack cyc %0d: got %b expected %b", cyc, tif.tbl_wr_ack, (cyc == c0 + 2));
         end
      end
      model[1] = x;
      d = cyc; tif.tbl_wr_req = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         n_checks++;
         if (tif.tbl_wr_ack !== 1'b0) begin
            n_fail++; $display("FAIL both_wr_ack_twice: got %b expected 0", tif.tbl_wr_ack);
         end
         if (tif.tbl_rd_ack === 1'b1) begin
            seen = 1'b1; tif.tbl_rd_req = 1'b0;
            n_checks += 2;
            if (cyc != d + 4) begin
               n_fail++; $display("FAIL both_rd_latency: got %0d expected 4", cyc - d);
            end
            if (tif.tbl_rd_data !== x) begin
               n_fail++; $display("FAIL both_rd_data: got %h expected %h", tif.tbl_rd_data, x);
            end
         end
      end
      n_checks++;
      if (!seen) begin
         n_fail++; $display("FAIL both_rd_timeout: got no ack expected ack");
         tif.tbl_rd_req = 1'b0;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      n_checks += 6;
      if (tif.tbl_rd_ack !== 1'b0 || tif.tbl_wr_ack !== 1'b0) begin
         n_fail++; $display("FAIL %s_acks: got rd %b wr %b expected 0 0", tag, tif.tbl_rd_ack, tif.tbl_wr_ack);
      end
      if (tif.lkp_ack !== 1'b0) begin n_fail++; $display("FAIL %s_lkp_ack: got %b expected 0", tag, tif.lkp_ack); end
      if (tif.tbl_rd_data !== '0) begin n_fail++; $display("FAIL %s_rd_data: got %h expected 0", tag, tif.tbl_rd_data); end
      if (tif.lkp_data !== '0) begin n_fail++; $display("FAIL %s_lkp_data: got %h expected 0", tag, tif.lkp_data); end
      if (tif.lkp_ready !== 1'b1) begin n_fail++; $display("FAIL %s_lkp_ready: got %b expected 1", tag, tif.lkp_ready); end
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL %s_lkp_pending: got %0d expected 0", tag, exp_q.size()); end
   endtask

   task automatic test_reset_inflight();
      logic [A-1:0] b, ra;
      int a;
      // Write stalled in PEND behind lookups, then reset before it commits.
      b = A'($urandom_range(0, ROWS - 1));
      tif.tbl_wr_req = 1'b1; tif.tbl_wr_addr = b; tif.tbl_wr_data = ~model[b];
      for (int k = 0; k < 4; k++) begin
         a = $urandom_range(0, ROWS - 1);
         tif.lkp_req = 1'b1; tif.lkp_addr = A'(a);
         if (k < 2) begin
            exp_q.push_back(model[a]); exp_cyc_q.push_back(cyc + 2);
         end
         if (k == 3) begin
            rstn = 1'b0; tif.tbl_wr_req = 1'b0;
         end
         @(negedge clk);
      end
      rstn = 1'b1; tif.lkp_req = 1'b0;
      check_reset_outputs("rst_wr");
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (tif.tbl_wr_ack !== 1'b0) begin
            n_fail++; $display("FAIL rst_wr_ack_after: got %b expected 0", tif.tbl_wr_ack);
         end
      end
      host_read(b);
      // Read interrupted by reset while its data is in the pipe.
      ra = A'($urandom_range(0, ROWS - 1));
      a = $urandom_range(0, ROWS - 1);
      tif.tbl_rd_req = 1'b1; tif.tbl_rd_addr = ra;
      tif.lkp_req = 1'b1; tif.lkp_addr = A'(a);
      exp_q.push_back(model[a]); exp_cyc_q.push_back(cyc + 2);
      @(negedge clk);
      tif.lkp_req = 1'b0;
      @(negedge clk);
      rstn = 1'b0; tif.tbl_rd_req = 1'b0;
      tif.lkp_req = 1'b1; tif.lkp_addr = A'($urandom_range(0, ROWS - 1));
      @(negedge clk);
      rstn = 1'b1; tif.lkp_req = 1'b0;
      check_reset_outputs("rst_rd");
      repeat (4) begin
         @(negedge clk);
         n_checks++;
         if (tif.tbl_rd_ack !== 1'b0) begin
            n_fail++; $display("FAIL rst_rd_ack_after: got %b expected 0", tif.tbl_rd_ack);
         end
      end
      host_read(ra);
   endtask

   initial begin
      rstn = 1'b0;
      tif.tbl_rd_req = 1'b0; tif.tbl_rd_addr = '0;
      tif.tbl_wr_req = 1'b0; tif.tbl_wr_addr = '0; tif.tbl_wr_data = '0;
      tif.lkp_req = 1'b0; tif.lkp_addr = '0;
      repeat (3) @(negedge clk);
      test_reset();
      rstn = 1'b1;
      @(negedge clk);
      fork
         monitor_lkp();
      join_none
      test_host_access();
      test_lookup_stream();
      test_starvation();
      test_wr_rd_collision();
      test_reset_inflight();
      repeat (4) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL lkp_missing: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
